calc_seq: RTL and testbench
===========================

# calc_seq

Sequential front end for the combinational `calc` unit. It accepts one operation request at a time (instr, a, b) over a valid/ready handshake, registers the operands onto `calc`'s inputs, and waits a fixed settle time. It then captures `calc`'s `result`/`code` and returns them over a second valid/ready handshake with backpressure. It sits between the instruction-issue logic and the `calc` instance, so `calc` sees stable, registered inputs.

## Interface
- SETTLE, 1, clock edges between driving `calc` inputs and sampling its outputs; must be ≥1; elaboration error otherwise
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_instr  in  16  instruction word
- req_a  in  16  operand a
- req_b  in  16  operand b
- calc_instr  out  16  registered instr to `calc.instr`
- calc_a  out  16  registered operand to `calc.a`
- calc_b  out  16  registered operand to `calc.b`
- calc_result  in  16  from `calc.result`
- calc_code  in  4  from `calc.code`
- resp_valid  out  1  response present
- resp_ready  in  1  downstream accepts response
- resp_result  out  16  captured result
- resp_code  out  4  captured code
- busy  out  1  high in any state other than IDLE
- op_count  out  16  completed operations (response handshakes), wraps 0xFFFF→0x0000

## Operation
- FSM states: IDLE, WAIT, RESP. All outputs are registered, except `req_ready` and `busy`, which decode the state.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`: latch `req_instr`/`req_a`/`req_b` into `calc_*`, load the settle counter with SETTLE-1, go to WAIT.
  - Request inputs are ignored when `req_valid`=0.
- WAIT:
  - `req_ready`=0.
  - If the counter is 0: capture `calc_result`→`resp_result` and `calc_code`→`resp_code`, set `resp_valid`=1, go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - `resp_valid`=1. `resp_result`/`resp_code` are held stable until the handshake.
  - On `resp_ready`=1: clear `resp_valid`, increment `op_count` (modulo 2^16), go to IDLE.
- `calc_*` hold their last value after capture, until the next accepted request. They are not cleared on response.
- `resp_result`/`resp_code` keep their last captured value after `resp_valid` drops.
- Only one operation is outstanding. `req_ready` is never high while `resp_valid` is high.
- `resp_ready` high in IDLE/WAIT has no effect.
- Width rules: pure pass-through; no arithmetic except the settle counter ($clog2(SETTLE+1) bits) and `op_count`.

## Timing
- Reset (async assert, sync-released by the system):
  - state = IDLE.
  - `calc_instr`/`calc_a`/`calc_b` = 0, `resp_result` = 0, `resp_code` = 0, `resp_valid` = 0, `op_count` = 0.
  - `req_ready` = 1 and `busy` = 0 as soon as `rst_n` is low.
- Reset mid-operation (WAIT or RESP): the operation is dropped with no response and `op_count` is not incremented. All outputs take their reset values immediately.
- Acceptance at edge E0: `calc_*` are valid after E0. Capture occurs at edge E0+SETTLE, so `resp_valid` is high after E0+SETTLE.
- With `resp_ready` held high:
  - The response handshake is at edge E0+SETTLE+1.
  - `req_ready` is high again after that edge.
  - The next acceptance is at E0+SETTLE+2 at the earliest. Throughput is 1 op per SETTLE+2 cycles.
- Backpressure: `resp_valid` stays high for any number of cycles. `op_count` changes only on the handshake edge.
- A request asserted during WAIT/RESP is not accepted. The requester must hold it until `req_ready`.

## Test plan
Bench stub for `calc`: `calc_result`=`calc_a`+`calc_b`, `calc_code`={3'b000, `calc_result`==0}.

- Reset check: `rst_n`=0 mid-stream → all outputs zero, `req_ready`=1, `busy`=0, `op_count`=0.
- Basic op, SETTLE=1: instr=16'hC100, a=1, b=2, `resp_ready`=1 → `resp_valid` one cycle after acceptance with `resp_result`=3 and `resp_code`=0000. `op_count`=1 after the handshake.
- Zero result, SETTLE=3: a=16'hFFFF, b=1 → `resp_result`=0, `resp_code`=0001. `resp_valid` rises 3 edges after acceptance.
- Backpressure: `resp_ready`=0 for 5 cycles → `resp_valid` and data stay stable. `req_ready` stays 0 even while `req_valid`=1 with new operands, and `calc_*` are unchanged. Handshake on cycle 6 → IDLE.
- Back-to-back: `req_valid` and `resp_ready` held high, 4 ops, SETTLE=1 → one acceptance every 3 cycles, results in order, `op_count`=4.
- Wrap and abort:
  - Force 65535 completions (or preload via hierarchical deposit) → next completion gives `op_count`=0.
  - Assert `rst_n`=0 while in WAIT → no `resp_valid`, `op_count`=0.

Source files
------------

// File: rtl/calc_seq.sv
`timescale 1ns/1ps
// calc_seq
//   Sequential front end for the combinational calc unit. It accepts one
//   request, registers its operands onto calc's inputs, waits SETTLE clock
//   edges, and then captures calc's result/code. It holds the captured values
//   on a response handshake that supports backpressure. Only one operation
//   can be outstanding at a time.
//
// Parameters
//   SETTLE       edges between driving calc inputs and sampling its outputs (>=1)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    request present
//   req_ready    block can accept a request (state decode)
//   req_instr    instruction word
//   req_a/req_b  operands
//   calc_instr   registered instruction to calc.instr
//   calc_a/b     registered operands to calc.a / calc.b
//   calc_result  calc.result
//   calc_code    calc.code
//   resp_valid   response present
//   resp_ready   downstream accepts response
//   resp_result  captured result
//   resp_code    captured code
//   busy         high in any state other than IDLE (state decode)
//   op_count     completed response handshakes, wraps modulo 2^16
//
// State table
//   state    | meaning
//   ST_IDLE  | ready for a request, calc_* hold the previous operands
//   ST_WAIT  | calc inputs driven, settle counter running down to zero
//   ST_RESP  | result captured, resp_valid high until resp_ready

module calc_seq #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_instr,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,

    output logic [15:0] calc_instr,
    output logic [15:0] calc_a,
    output logic [15:0] calc_b,
    input  logic [15:0] calc_result,
    input  logic [3:0]  calc_code,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_result,
    output logic [3:0]  resp_code,

    output logic        busy,
    output logic [15:0] op_count
);

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("calc_seq: SETTLE must be >= 1");
        end
    endgenerate

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic [15:0]      op_cnt_q;

    // req_ready and busy decode the state directly, so they follow an
    // asynchronous reset immediately without waiting for a clock edge.
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign op_count  = op_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            calc_instr  <= '0;
            calc_a      <= '0;
            calc_b      <= '0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_code   <= '0;
            op_cnt_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        calc_instr <= req_instr;
                        calc_a     <= req_a;
                        calc_b     <= req_b;
                        // Counting SETTLE-1 down to zero puts the capture
                        // exactly SETTLE edges after acceptance.
                        settle_cnt <= CNT_LOAD;
                        state      <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (settle_cnt == '0) begin
                        resp_result <= calc_result;
                        resp_code   <= calc_code;
                        resp_valid  <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        op_cnt_q   <= op_cnt_q + 16'd1;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq.sv
`timescale 1ns/1ps
// Bench for calc_seq: two instances (SETTLE=1 and SETTLE=3), each with an
// adder stub standing in for calc. A transaction-level model predicts every
// output, and the model is compared against the DUT on each falling edge.
// Directed sequences add hand-computed literal expectations.
module tb_calc_seq;

    logic clk;
    logic rst_n;

    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [15:0] req_instr   [2];
    logic [15:0] req_a       [2];
    logic [15:0] req_b       [2];
    logic [15:0] calc_instr  [2];
    logic [15:0] calc_a      [2];
    logic [15:0] calc_b      [2];
    logic [15:0] calc_result [2];
    logic [3:0]  calc_code   [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [15:0] resp_result [2];
    logic [3:0]  resp_code   [2];
    logic        busy        [2];
    logic [15:0] op_count    [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // calc stub: result = a + b, code flags a zero result
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            calc_result[k] = calc_a[k] + calc_b[k];
            calc_code[k]   = {3'b000, (calc_result[k] == 16'd0)};
        end
    end

    calc_seq #(.SETTLE(1)) u_s0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_instr(req_instr[0]), .req_a(req_a[0]), .req_b(req_b[0]),
        .calc_instr(calc_instr[0]), .calc_a(calc_a[0]), .calc_b(calc_b[0]),
        .calc_result(calc_result[0]), .calc_code(calc_code[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_result(resp_result[0]), .resp_code(resp_code[0]),
        .busy(busy[0]), .op_count(op_count[0])
    );

    calc_seq #(.SETTLE(3)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_instr(req_instr[1]), .req_a(req_a[1]), .req_b(req_b[1]),
        .calc_instr(calc_instr[1]), .calc_a(calc_a[1]), .calc_b(calc_b[1]),
        .calc_result(calc_result[1]), .calc_code(calc_code[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_result(resp_result[1]), .resp_code(resp_code[1]),
        .busy(busy[1]), .op_count(op_count[1])
    );

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An operation is outstanding from acceptance until the response
    // handshake. The response appears SETTLE edges after acceptance and
    // carries a+b of the accepted operands.
    bit          m_out  [2];
    bit          m_rv   [2];
    int          m_due  [2];
    logic [15:0] m_ci   [2];
    logic [15:0] m_ca   [2];
    logic [15:0] m_cb   [2];
    logic [15:0] m_res  [2];
    logic [3:0]  m_code [2];
    logic [15:0] m_cnt  [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_out[k] = 0; m_rv[k] = 0; m_due[k] = 0;
                m_ci[k] = 0; m_ca[k] = 0; m_cb[k] = 0;
                m_res[k] = 0; m_code[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_out[k]) begin
                    if (req_valid[k]) begin
                        m_out[k] = 1;
                        m_due[k] = settle_of(k);
                        m_ci[k]  = req_instr[k];
                        m_ca[k]  = req_a[k];
                        m_cb[k]  = req_b[k];
                    end
                end else if (!m_rv[k]) begin
                    m_due[k] = m_due[k] - 1;
                    if (m_due[k] == 0) begin
                        m_rv[k]   = 1;
                        m_res[k]  = m_ca[k] + m_cb[k];
                        m_code[k] = (m_res[k] == 16'd0) ? 4'd1 : 4'd0;
                    end
                end else if (resp_ready[k]) begin
                    m_rv[k]  = 0;
                    m_out[k] = 0;
                    m_cnt[k] = m_cnt[k] + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.req_ready", k),   32'(req_ready[k]),   32'(!m_out[k]));
            chk($sformatf("u%0d.busy", k),        32'(busy[k]),        32'(m_out[k]));
            chk($sformatf("u%0d.resp_valid", k),  32'(resp_valid[k]),  32'(m_rv[k]));
            chk($sformatf("u%0d.resp_result", k), 32'(resp_result[k]), 32'(m_res[k]));
            chk($sformatf("u%0d.resp_code", k),   32'(resp_code[k]),   32'(m_code[k]));
            chk($sformatf("u%0d.calc_instr", k),  32'(calc_instr[k]),  32'(m_ci[k]));
            chk($sformatf("u%0d.calc_a", k),      32'(calc_a[k]),      32'(m_ca[k]));
            chk($sformatf("u%0d.calc_b", k),      32'(calc_b[k]),      32'(m_cb[k]));
            chk($sformatf("u%0d.op_count", k),    32'(op_count[k]),    32'(m_cnt[k]));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input int k, input logic [15:0] i, input logic [15:0] a,
                         input logic [15:0] b, output time acc_t);
        bit ok;
        ok = 0;
        acc_t = 0;
        req_instr[k] = i;
        req_a[k]     = a;
        req_b[k]     = b;
        req_valid[k] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (req_ready[k]) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("u%0d.accept_timeout", k), 32'(ok), 32'd1);
        @(posedge clk);
        acc_t = $time;
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    // Returns number of edges from acceptance to resp_valid rising.
    task automatic wait_resp(input int k, input time acc_t, output int lat);
        bit ok;
        ok = 0;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (resp_valid[k]) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("u%0d.resp_timeout", k), 32'(ok), 32'd1);
        if (ok) lat = int'(($time - 5 - acc_t) / 10);
    endtask

    task automatic chk_reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s u%0d req_ready", tag, k),   32'(req_ready[k]),   32'd1);
            chk($sformatf("%s u%0d busy", tag, k),        32'(busy[k]),        32'd0);
            chk($sformatf("%s u%0d resp_valid", tag, k),  32'(resp_valid[k]),  32'd0);
            chk($sformatf("%s u%0d op_count", tag, k),    32'(op_count[k]),    32'd0);
            chk($sformatf("%s u%0d calc_a", tag, k),      32'(calc_a[k]),      32'd0);
            chk($sformatf("%s u%0d calc_instr", tag, k),  32'(calc_instr[k]),  32'd0);
            chk($sformatf("%s u%0d resp_result", tag, k), 32'(resp_result[k]), 32'd0);
            chk($sformatf("%s u%0d resp_code", tag, k),   32'(resp_code[k]),   32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        time t;
        time acc [4];
        int  lat;
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [15:0] exp_res [4];
        logic [15:0] got [$];

        va = '{16'd10, 16'd100, 16'hFFFE, 16'd7};
        vb = '{16'd20, 16'd1,   16'd2,    16'd8};
        exp_res = '{16'd30, 16'd101, 16'd0, 16'd15};

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_instr[k] = 0; req_a[k] = 0; req_b[k] = 0;
            resp_ready[k] = 0;
        end
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic op, SETTLE=1
        resp_ready[0] = 1'b1;
        issue(0, 16'hC100, 16'd1, 16'd2, t);
        wait_resp(0, t, lat);
        chk("basic latency", 32'(lat), 32'd1);
        chk("basic result", 32'(resp_result[0]), 32'd3);
        chk("basic code", 32'(resp_code[0]), 32'd0);
        chk("basic calc_instr", 32'(calc_instr[0]), 32'hC100);
        @(negedge clk);
        chk("basic op_count", 32'(op_count[0]), 32'd1);
        chk("basic resp_valid drop", 32'(resp_valid[0]), 32'd0);
        chk("basic result held", 32'(resp_result[0]), 32'd3);

        // zero result, SETTLE=3
        resp_ready[1] = 1'b1;
        issue(1, 16'h0001, 16'hFFFF, 16'd1, t);
        wait_resp(1, t, lat);
        chk("zero latency", 32'(lat), 32'd3);
        chk("zero result", 32'(resp_result[1]), 32'd0);
        chk("zero code", 32'(resp_code[1]), 32'd1);
        @(negedge clk);
        chk("zero op_count", 32'(op_count[1]), 32'd1);

        // backpressure on SETTLE=3 instance with a competing request
        resp_ready[1] = 1'b0;
        issue(1, 16'h1234, 16'd5, 16'd6, t);
        wait_resp(1, t, lat);
        req_instr[1] = 16'hABCD;
        req_a[1]     = 16'd9;
        req_b[1]     = 16'd9;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp resp_valid", 32'(resp_valid[1]), 32'd1);
            chk("bp result", 32'(resp_result[1]), 32'd11);
            chk("bp req_ready", 32'(req_ready[1]), 32'd0);
            chk("bp calc_a", 32'(calc_a[1]), 32'd5);
            chk("bp calc_instr", 32'(calc_instr[1]), 32'h1234);
            chk("bp op_count", 32'(op_count[1]), 32'd1);
            if (i < 4) @(negedge clk);
        end
        resp_ready[1] = 1'b1;
        @(negedge clk);
        chk("bp handshake resp_valid", 32'(resp_valid[1]), 32'd0);
        chk("bp handshake req_ready", 32'(req_ready[1]), 32'd1);
        chk("bp handshake op_count", 32'(op_count[1]), 32'd2);
        chk("bp result held", 32'(resp_result[1]), 32'd11);
        req_valid[1] = 1'b0;
        @(negedge clk);

        // abort while the SETTLE=3 instance is in WAIT
        issue(1, 16'h0002, 16'd2, 16'd3, t);
        chk("abort in wait", 32'(busy[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort no resp", 32'(resp_valid[1]), 32'd0);
            chk("abort op_count", 32'(op_count[1]), 32'd0);
        end

        // back-to-back, SETTLE=1
        resp_ready[0] = 1'b1;
        fork
            begin
                req_instr[0] = 16'h00B0;
                req_a[0]     = va[0];
                req_b[0]     = vb[0];
                req_valid[0] = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    bit ok;
                    ok = 0;
                    for (int n = 0; n < 20; n++) begin
                        if (req_ready[0]) begin
                            ok = 1;
                            break;
                        end
                        @(negedge clk);
                    end
                    chk("b2b accept_timeout", 32'(ok), 32'd1);
                    @(posedge clk);
                    acc[j] = $time;
                    @(negedge clk);
                    if (j < 3) begin
                        req_a[0] = va[j+1];
                        req_b[0] = vb[j+1];
                    end else begin
                        req_valid[0] = 1'b0;
                    end
                end
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    @(negedge clk);
                    if (resp_valid[0]) got.push_back(resp_result[0]);
                    if (got.size() == 4) break;
                end
            end
        join
        chk("b2b resp count", 32'(got.size()), 32'd4);
        for (int j = 1; j < 4; j++)
            chk($sformatf("b2b spacing %0d", j), 32'(acc[j] - acc[j-1]), 32'd30);
        for (int j = 0; j < 4; j++)
            if (j < got.size())
                chk($sformatf("b2b result %0d", j), 32'(got[j]), 32'(exp_res[j]));
        @(negedge clk);
        chk("b2b op_count", 32'(op_count[0]), 32'd4);

        // op_count wrap via deposit
        #2;
        u_s0.op_cnt_q = 16'hFFFF;
        m_cnt[0] = 16'hFFFF;
        @(negedge clk);
        chk("wrap preload", 32'(op_count[0]), 32'hFFFF);
        issue(0, 16'h0003, 16'd4, 16'd4, t);
        wait_resp(0, t, lat);
        chk("wrap result", 32'(resp_result[0]), 32'd8);
        @(negedge clk);
        chk("wrap op_count", 32'(op_count[0]), 32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
